alu_seq: RTL and testbench

ALU_SEQ -- requirements
Module: alu_seq

---
 rtl/alu_seq.sv | 200 ++++++++++++++++++++
 tb/tb_alu_seq.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// Multi-cycle ALU with start/busy/done handshake and registered result, zero and divByZero flags.
// Define ALU_SEQ_MULDIV_EN to build the iterative shift-add multiplier and restoring divider.
module alu_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] data1,
    input  logic [WIDTH-1:0] data2,
    input  logic [5:0]       operation,
    input  logic [1:0]       ALUOp,
    output logic             busy,
    output logic             done,
    output logic             zero,
    output logic             divByZero,
    output logic [WIDTH-1:0] aluResult
);
    localparam int SHW = $clog2(WIDTH);
    localparam int CW  = SHW + 1;

    localparam logic [5:0] OP_MUL = 6'b001001;
    localparam logic [5:0] OP_DIV = 6'b001010;
    localparam logic [5:0] OP_MOD = 6'b001011;

`ifdef ALU_SEQ_MULDIV_EN
    typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, ITER = 2'd2, DONE = 2'd3} state_t;
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
`else
    typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, DONE = 2'd3} state_t;
`endif

    state_t           state_r;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [5:0]       op_r;
    logic [1:0]       aluop_r;
    logic             cmp_s;
    logic             dbz_s;

    // Single-cycle result; a zero divisor yields all-ones quotient and remainder = dividend.
    function automatic logic [WIDTH-1:0] alu_fn(input logic [1:0] mode, input logic [5:0] op,
                                                input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        logic [WIDTH-1:0] r;
        r = {WIDTH{1'b0}};
        case (mode)
            2'b01, 2'b11: r = b;
            2'b10:        r = a - b;
            2'b00: begin
                case (op)
                    6'b000000: r = a;
                    6'b000001: r = a + b;
                    6'b000010: r = a - b;
                    6'b000011: r = a & b;
                    6'b000100: r = a | b;
                    6'b000101: r = a ^ b;
                    6'b000110: r = ~a;
                    6'b000111: r = a << b[SHW-1:0];
                    6'b001000: r = a >> b[SHW-1:0];
`ifdef ALU_SEQ_MULDIV_EN
                    OP_DIV:    r = {WIDTH{1'b1}};
                    OP_MOD:    r = a;
`endif
                    default:   r = {WIDTH{1'b0}};
                endcase
            end
            default: r = {WIDTH{1'b0}};
        endcase
        return r;
    endfunction

    // Compare flag and divide-by-zero flag from the latched request.
    always_comb begin
        cmp_s = (aluop_r == 2'b10) ? (a_r != b_r) : (a_r == b_r);
`ifdef ALU_SEQ_MULDIV_EN
        dbz_s = (aluop_r == 2'b00) && ((op_r == OP_DIV) || (op_r == OP_MOD)) && (b_r == {WIDTH{1'b0}});
`else
        dbz_s = 1'b0;
`endif
    end

`ifdef ALU_SEQ_MULDIV_EN
    logic [CW-1:0]    cnt_r;
    logic [WIDTH:0]   acc_r;
    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] mc_r;
    logic [WIDTH:0]   acc_nx_s;
    logic [WIDTH-1:0] q_nx_s;
    logic [WIDTH-1:0] mc_nx_s;
    logic [WIDTH:0]   rem_sh_s;
    logic [WIDTH:0]   rem_sub_s;
    logic             needs_iter_s;

    // One iteration: shift-add for multiply, restore-or-keep step for divide (borrow = sub MSB).
    always_comb begin
        rem_sh_s  = {acc_r[WIDTH-1:0], q_r[WIDTH-1]};
        rem_sub_s = rem_sh_s - {1'b0, b_r};
        mc_nx_s   = mc_r << 1;
        if (op_r == OP_MUL) begin
            acc_nx_s = {1'b0, acc_r[WIDTH-1:0] + (q_r[0] ? mc_r : {WIDTH{1'b0}})};
            q_nx_s   = q_r >> 1;
        end else if (rem_sub_s[WIDTH]) begin
            acc_nx_s = rem_sh_s;
            q_nx_s   = {q_r[WIDTH-2:0], 1'b0};
        end else begin
            acc_nx_s = rem_sub_s;
            q_nx_s   = {q_r[WIDTH-2:0], 1'b1};
        end
        needs_iter_s = (aluop_r == 2'b00) &&
                       ((op_r == OP_MUL) || (((op_r == OP_DIV) || (op_r == OP_MOD)) && !dbz_s));
    end
`endif

    // Control FSM with registered handshake and result outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r   <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            zero      <= 1'b0;
            divByZero <= 1'b0;
            aluResult <= {WIDTH{1'b0}};
            a_r       <= {WIDTH{1'b0}};
            b_r       <= {WIDTH{1'b0}};
            op_r      <= 6'd0;
            aluop_r   <= 2'd0;
`ifdef ALU_SEQ_MULDIV_EN
            cnt_r     <= {CW{1'b0}};
            acc_r     <= {(WIDTH+1){1'b0}};
            q_r       <= {WIDTH{1'b0}};
            mc_r      <= {WIDTH{1'b0}};
`endif
        end else begin
            done <= 1'b0;
            case (state_r)
                IDLE, DONE: begin
                    if (start) begin
                        a_r     <= data1;
                        b_r     <= data2;
                        op_r    <= operation;
                        aluop_r <= ALUOp;
                        busy    <= 1'b1;
                        state_r <= EXEC;
                    end else begin
                        busy    <= 1'b0;
                        state_r <= IDLE;
                    end
                end
                EXEC: begin
`ifdef ALU_SEQ_MULDIV_EN
                    if (needs_iter_s) begin
                        acc_r   <= {(WIDTH+1){1'b0}};
                        q_r     <= (op_r == OP_MUL) ? b_r : a_r;
                        mc_r    <= a_r;
                        cnt_r   <= {CW{1'b0}};
                        state_r <= ITER;
                    end else begin
                        aluResult <= alu_fn(aluop_r, op_r, a_r, b_r);
                        zero      <= cmp_s;
                        divByZero <= dbz_s;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        state_r   <= DONE;
                    end
`else
                    aluResult <= alu_fn(aluop_r, op_r, a_r, b_r);
                    zero      <= cmp_s;
                    divByZero <= dbz_s;
                    busy      <= 1'b0;
                    done      <= 1'b1;
                    state_r   <= DONE;
`endif
                end
`ifdef ALU_SEQ_MULDIV_EN
                ITER: begin
                    acc_r <= acc_nx_s;
                    q_r   <= q_nx_s;
                    mc_r  <= mc_nx_s;
                    cnt_r <= cnt_r + CNT_ONE;
                    if (cnt_r == CNT_LAST) begin
                        aluResult <= (op_r == OP_DIV) ? q_nx_s : acc_nx_s[WIDTH-1:0];
                        zero      <= cmp_s;
                        divByZero <= 1'b0;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        state_r   <= DONE;
                    end else begin
                        state_r <= ITER;
                    end
                end
`endif
                default: begin
                    busy    <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq (WIDTH = 32): directed steps plus randomized requests
// checked against a behavioural model; honours ALU_SEQ_MULDIV_EN when defined.
module tb_alu_seq;
    logic        clock = 1'b0;
    logic        reset_n;
    logic        start;
    logic [31:0] data1;
    logic [31:0] data2;
    logic [5:0]  operation;
    logic [1:0]  ALUOp;
    logic        busy;
    logic        done;
    logic        zero;
    logic        divByZero;
    logic [31:0] aluResult;

    int checks = 0;
    int errors = 0;

    logic [31:0] prev_r;
    logic        prev_z;
    logic        prev_d;

    alu_seq #(.WIDTH(32)) dut (
        .clock(clock), .reset_n(reset_n), .start(start), .data1(data1), .data2(data2),
        .operation(operation), .ALUOp(ALUOp), .busy(busy), .done(done), .zero(zero),
        .divByZero(divByZero), .aluResult(aluResult)
    );

    always #5 clock = ~clock;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference behaviour: result, zero, divByZero and clock edges from start to done.
    task automatic model(input logic [1:0] mode, input logic [5:0] op, input logic [31:0] a,
                         input logic [31:0] b, output logic [31:0] r, output logic z,
                         output logic dz, output int lat);
        z   = (mode == 2'b10) ? (a != b) : (a == b);
        dz  = 1'b0;
        lat = 1;
        r   = 32'd0;
        if (mode == 2'b01 || mode == 2'b11) r = b;
        else if (mode == 2'b10) r = a - b;
        else begin
            case (op)
                6'd0: r = a;
                6'd1: r = a + b;
                6'd2: r = a - b;
                6'd3: r = a & b;
                6'd4: r = a | b;
                6'd5: r = a ^ b;
                6'd6: r = ~a;
                6'd7: r = a << b[4:0];
                6'd8: r = a >> b[4:0];
`ifdef ALU_SEQ_MULDIV_EN
                6'd9: begin r = a * b; lat = 33; end
                6'd10: if (b == 32'd0) begin r = 32'hFFFF_FFFF; dz = 1'b1; end
                       else begin r = a / b; lat = 33; end
                6'd11: if (b == 32'd0) begin r = a; dz = 1'b1; end
                       else begin r = a % b; lat = 33; end
`endif
                default: r = 32'd0;
            endcase
        end
    endtask

    // Issue one request (caller must be #1 after an edge); junk start pulses while busy.
    task automatic run_op(input string tag, input logic [1:0] mode, input logic [5:0] op,
                          input logic [31:0] a, input logic [31:0] b);
        logic [31:0] er;
        logic        ez;
        logic        ed;
        int          el;
        int          lat;
        model(mode, op, a, b, er, ez, ed, el);
        start = 1'b1; ALUOp = mode; operation = op; data1 = a; data2 = b;
        @(posedge clock); #1;
        chk({tag, "_busy"}, {63'd0, busy}, 64'd1);
        lat = 0;
        while (!done && lat < 100) begin
            chk({tag, "_hold"}, {31'd0, prev_d, prev_z, aluResult}, {31'd0, prev_d, prev_z, prev_r});
            start = 1'($urandom_range(0, 1));
            data1 = $urandom; data2 = $urandom;
            operation = 6'($urandom_range(0, 63)); ALUOp = 2'($urandom_range(0, 3));
            @(posedge clock); #1;
            lat++;
        end
        start = 1'b0;
        chk({tag, "_lat"}, 64'(lat), 64'(el));
        chk({tag, "_res"}, {32'd0, aluResult}, {32'd0, er});
        chk({tag, "_flags"}, {61'd0, busy, zero, divByZero}, {61'd0, 1'b0, ez, ed});
        prev_r = er; prev_z = ez; prev_d = ed;
    endtask

    task automatic idle_gap();
        @(posedge clock); #1;
        chk("done_pulse", {62'd0, done, busy}, 64'd0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk(tag, {29'd0, busy, done, zero, divByZero, aluResult}, 64'd0);
    endtask

    initial begin
        reset_n = 1'b0; start = 1'b0; data1 = 32'd0; data2 = 32'd0;
        operation = 6'd0; ALUOp = 2'd0;
        prev_r = 32'd0; prev_z = 1'b0; prev_d = 1'b0;
        #2;
        chk_reset_outputs("reset_state");
        repeat (3) @(posedge clock);
        #1 reset_n = 1'b1;
        idle_gap();

        run_op("add_5_7", 2'b00, 6'd1, 32'd5, 32'd7);
        idle_gap();
        run_op("mul_ff_2", 2'b00, 6'd9, 32'hFFFF_FFFF, 32'd2);
        idle_gap();
        run_op("div_100_7", 2'b00, 6'd10, 32'd100, 32'd7);
        run_op("mod_100_7", 2'b00, 6'd11, 32'd100, 32'd7);
        run_op("div_by_0", 2'b00, 6'd10, 32'd100, 32'd0);
        run_op("mod_by_0", 2'b00, 6'd11, 32'd100, 32'd0);
        idle_gap();
        run_op("bne_eq", 2'b10, 6'd1, 32'd9, 32'd9);
        run_op("beq_eq", 2'b00, 6'd1, 32'd9, 32'd9);
        run_op("pass_b", 2'b01, 6'd5, 32'd77, 32'h1234);
        run_op("shl_big", 2'b00, 6'd7, 32'h0000_0003, 32'hFFFF_FFE4);
        run_op("shr_big", 2'b00, 6'd8, 32'h8000_0000, 32'h0000_0103);
        run_op("op_undef", 2'b00, 6'd63, 32'd1, 32'd2);
        run_op("mul_3_4", 2'b00, 6'd9, 32'd3, 32'd4);
        idle_gap();

`ifdef ALU_SEQ_MULDIV_EN
        start = 1'b1; ALUOp = 2'b00; operation = 6'd9; data1 = 32'd123; data2 = 32'd456;
        @(posedge clock); #1;
        start = 1'b0;
        for (int i = 0; i < 11; i++) begin
            @(posedge clock); #1;
            chk("abort_no_done", {63'd0, done}, 64'd0);
        end
`endif
        reset_n = 1'b0;
        #1;
        chk_reset_outputs("reset_async");
        for (int i = 0; i < 3; i++) begin
            @(posedge clock); #1;
            chk_reset_outputs("reset_hold");
        end
        reset_n = 1'b1;
        prev_r = 32'd0; prev_z = 1'b0; prev_d = 1'b0;
        idle_gap();
        run_op("add_1_1", 2'b00, 6'd1, 32'd1, 32'd1);
        idle_gap();

        for (int i = 0; i < 48; i++) begin
            logic [1:0]  m;
            logic [5:0]  o;
            logic [31:0] a;
            logic [31:0] b;
            m = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
            o = 6'($urandom_range(0, 15));
            if ($urandom_range(0, 9) == 0) o = 6'($urandom_range(16, 63));
            a = $urandom; b = $urandom;
            case ($urandom_range(0, 3))
                0: b = 32'($urandom_range(0, 9));
                1: b = a;
                default: b = b;
            endcase
            if ($urandom_range(0, 2) == 0) idle_gap();
            run_op("rand", m, o, a, b);
        end
        idle_gap();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
